// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a byte FIFO, emitting frames back-to-back
// while the FIFO has data and enable is high.
module fifo_uart_tx #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       serial_out,
    output logic       tx_busy
);

    localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
    // A one-cycle symbol would give a zero-width counter; keep at least one bit.
    localparam int CW = (CLOCK_COUNTER_WIDTH < 1) ? 1 : CLOCK_COUNTER_WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic          serial_n;
    logic          cnt_last;
    logic          pop;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        cnt_last  = (cnt == CNT_LAST);
        pop       = enable && !fifo_empty && !rst &&
                    ((state == IDLE) || ((state == STOP) && cnt_last));

        case (state)
            IDLE: begin
                if (pop) begin
                    shift_n = fifo_dout;
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_n = '0;
                    if (pop) begin
                        shift_n = fifo_dout;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is computed from next-state values so the flop presents
        // each bit in the same cycle the state register enters it.
        case (state_n)
            START:   serial_n = 1'b0;
            DATA:    serial_n = shift_n[0];
            default: serial_n = 1'b1;
        endcase

        fifo_rd_en = pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_n;
            serial_out <= serial_n;
        end
    end

    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a byte FIFO model feeds the DUT and a queue of
// expected line levels (one entry per clock) predicts serial_out/tx_busy/pops.
module tb_fifo_uart_tx;

    localparam int S = 10;  // 1000 Hz / 100 baud

    logic       clk = 1'b0;
    logic       rst, enable, fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en, serial_out, tx_busy;

    fifo_uart_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .serial_out(serial_out), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];        // FIFO contents
    bit         exp_line[$]; // expected line level per future cycle
    bit         hold_empty;
    bit         valid;
    bit         exp_so, exp_busy, exp_rd;
    int         errors, checks;

    // Present FIFO outputs for this cycle and derive expectations.
    task automatic tick_eval();
        fifo_empty = hold_empty || (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
        #1;
        exp_so   = (exp_line.size() != 0) ? exp_line[0] : 1'b1;
        exp_busy = (exp_line.size() != 0);
        // A pop is legal only when this cycle is idle or the last stop cycle.
        exp_rd   = !rst && enable && !fifo_empty && (exp_line.size() <= 1);
    endtask

    task automatic tick_adv();
        if (exp_line.size() != 0) void'(exp_line.pop_front());
        if (exp_rd) begin
            for (int k = 0; k < S; k++) exp_line.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int k = 0; k < S; k++) exp_line.push_back(fifo_dout[b]);
            for (int k = 0; k < S; k++) exp_line.push_back(1'b1);
        end
        if (rst) begin
            exp_line.delete();
            valid = 1'b1;
        end
        if (fifo_rd_en && !fifo_empty && q.size() != 0) void'(q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; hold_empty = 1'b0;
        q.push_back(8'($urandom));
        for (int c = 0; c < 3; c++) begin
            tick_eval();
            checks++;
            if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd c=%0d got=%b exp=0", c, fifo_rd_en); end
            if (c > 0) begin
                checks += 2;
                if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_line c=%0d got=%b exp=1", c, serial_out); end
                if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy c=%0d got=%b exp=0", c, tx_busy); end
            end
            tick_adv();
        end
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick_eval();
            if (c == 0) begin
                checks++;
                if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL reset_first_pop got=%b exp=1", fifo_rd_en); end
            end
            checks += 3;
            if (serial_out !== exp_so) begin errors++; $display("FAIL reset_drain_line c=%0d got=%b exp=%b", c, serial_out, exp_so); end
            if (tx_busy !== exp_busy) begin errors++; $display("FAIL reset_drain_busy c=%0d got=%b exp=%b", c, tx_busy, exp_busy); end
            if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL reset_drain_rd c=%0d got=%b exp=%b", c, fifo_rd_en, exp_rd); end
            tick_adv();
        end
    endtask

    task automatic test_single();
        int pulses = 0, busy_cnt = 0;
        logic [9:0] pat, obs;
        pat = {1'b1, 8'hA5, 1'b0};
        obs = '0;
        q.push_back(8'hA5);
        for (int c = 0; c < 130; c++) begin
            tick_eval();
            checks += 3;
            if (serial_out !== exp_so) begin errors++; $display("FAIL single_line c=%0d got=%b exp=%b", c, serial_out, exp_so); end
            if (tx_busy !== exp_busy) begin errors++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, tx_busy, exp_busy); end
            if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL single_rd c=%0d got=%b exp=%b", c, fifo_rd_en, exp_rd); end
            if (fifo_rd_en === 1'b1) pulses++;
            if (tx_busy === 1'b1) busy_cnt++;
            if (c >= 5 && c < 105 && (c % S) == 5) obs[(c - 5) / S] = serial_out;
            tick_adv();
        end
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        if (busy_cnt != 100) begin errors++; $display("FAIL single_busy_len got=%0d exp=100", busy_cnt); end
        if (obs !== pat) begin errors++; $display("FAIL single_pattern got=%b exp=%b", obs, pat); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, run = 0, max_run = 0, p1 = -1, p2 = -1;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        for (int c = 0; c < 230; c++) begin
            tick_eval();
            checks += 3;
            if (serial_out !== exp_so) begin errors++; $display("FAIL b2b_line c=%0d got=%b exp=%b", c, serial_out, exp_so); end
            if (tx_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, tx_busy, exp_busy); end
            if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL b2b_rd c=%0d got=%b exp=%b", c, fifo_rd_en, exp_rd); end
            if (fifo_rd_en === 1'b1) begin
                pulses++;
                if (p1 < 0) p1 = c; else p2 = c;
            end
            if (tx_busy === 1'b1) run++; else run = 0;
            if (run > max_run) max_run = run;
            tick_adv();
        end
        checks += 3;
        if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        if (p2 - p1 != 10 * S) begin errors++; $display("FAIL b2b_period got=%0d exp=%0d", p2 - p1, 10 * S); end
        if (max_run != 20 * S) begin errors++; $display("FAIL b2b_busy_run got=%0d exp=%0d", max_run, 20 * S); end
    endtask

    task automatic test_flow_control();
        int stray = 0;
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        for (int c = 0; c < 470; c++) begin
            if (c == 40) enable = 1'b0;
            if (c == 150) enable = 1'b1;
            tick_eval();
            checks += 3;
            if (serial_out !== exp_so) begin errors++; $display("FAIL flow_line c=%0d got=%b exp=%b", c, serial_out, exp_so); end
            if (tx_busy !== exp_busy) begin errors++; $display("FAIL flow_busy c=%0d got=%b exp=%b", c, tx_busy, exp_busy); end
            if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL flow_rd c=%0d got=%b exp=%b", c, fifo_rd_en, exp_rd); end
            if (c >= 40 && c < 150 && fifo_rd_en === 1'b1) stray++;
            if (c == 150) begin
                checks++;
                if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flow_resume_pop got=%b exp=1", fifo_rd_en); end
            end
            if (c == 151) begin
                checks++;
                if (serial_out !== 1'b0) begin errors++; $display("FAIL flow_resume_start got=%b exp=0", serial_out); end
            end
            tick_adv();
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL flow_stray_pops got=%0d exp=0", stray); end
    endtask

    task automatic test_reset_midframe();
        int rst_pops = 0;
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        for (int c = 0; c < 160; c++) begin
            if (c == 35) rst = 1'b1;
            if (c == 37) rst = 1'b0;
            tick_eval();
            checks += 3;
            if (serial_out !== exp_so) begin errors++; $display("FAIL midrst_line c=%0d got=%b exp=%b", c, serial_out, exp_so); end
            if (tx_busy !== exp_busy) begin errors++; $display("FAIL midrst_busy c=%0d got=%b exp=%b", c, tx_busy, exp_busy); end
            if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL midrst_rd c=%0d got=%b exp=%b", c, fifo_rd_en, exp_rd); end
            if (rst && fifo_rd_en === 1'b1) rst_pops++;
            if (c == 36) begin
                checks += 2;
                if (serial_out !== 1'b1) begin errors++; $display("FAIL midrst_idle_line got=%b exp=1", serial_out); end
                if (tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got=%b exp=0", tx_busy); end
            end
            tick_adv();
        end
        checks++;
        if (rst_pops != 0) begin errors++; $display("FAIL midrst_pops got=%0d exp=0", rst_pops); end
    endtask

    task automatic test_empty_guard();
        int guard_hits = 0;
        bit drained = 1'b0;
        for (int c = 0; c < 4000 && !drained; c++) begin
            if (c < 2000) begin
                if ($urandom_range(0, 19) == 0 && q.size() < 8) q.push_back(8'($urandom));
                hold_empty = ($urandom_range(0, 3) == 0);
                enable     = ($urandom_range(0, 9) != 0);
            end else begin
                hold_empty = 1'b0;
                enable     = 1'b1;
            end
            tick_eval();
            checks += 4;
            if (serial_out !== exp_so) begin errors++; $display("FAIL guard_line c=%0d got=%b exp=%b", c, serial_out, exp_so); end
            if (tx_busy !== exp_busy) begin errors++; $display("FAIL guard_busy c=%0d got=%b exp=%b", c, tx_busy, exp_busy); end
            if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL guard_rd c=%0d got=%b exp=%b", c, fifo_rd_en, exp_rd); end
            if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) begin
                guard_hits++;
                errors++;
                $display("FAIL guard_pop_while_empty c=%0d got=1 exp=0", c);
            end
            if (c >= 2000 && q.size() == 0 && exp_line.size() == 0) drained = 1'b1;
            tick_adv();
        end
        checks++;
        if (!drained) begin errors++; $display("FAIL guard_drain_timeout left=%0d exp=0", q.size() + exp_line.size()); end
    endtask

    initial begin
        errors = 0; checks = 0; valid = 1'b0;
        rst = 1'b1; enable = 1'b1; hold_empty = 1'b0;
        fifo_empty = 1'b1; fifo_dout = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_reset_midframe();
        test_empty_guard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
